// File: rtl/dac_pkg.sv
// dac_pkg: shared types and constants for the serial audio DAC transmitter.
//   dac_state_e      - transmitter state (idle, streaming, finishing last frame)
//   FRAME_BITS       - bclk periods per lrck frame (two 16-bit slots)
//   WORD_BITS        - bits per audio word
//   BCLK_DIV_DEFAULT - default clk cycles per bclk half-period
package dac_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } dac_state_e;

    localparam int unsigned FRAME_BITS       = 32;
    localparam int unsigned WORD_BITS        = 16;
    localparam int unsigned BCLK_DIV_DEFAULT = 16;
    localparam int unsigned DIV_CNT_W        = 8;

endpackage

// File: rtl/bclk_gen.sv
// bclk_gen: divides clk down to the serial bit clock.
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   clear_i      synchronous clear; holds divider and bclk at 0
//   bclk_o       registered bit clock, 50% duty, period 2*BCLK_DIV clk
//   fall_stb_o   high in the clk cycle whose ending edge drives bclk 1->0
//   rise_stb_o   high in the clk cycle whose ending edge drives bclk 0->1
module bclk_gen
    import dac_pkg::*;
#(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic bclk_o,
    output logic fall_stb_o,
    output logic rise_stb_o
);

    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 bclk_q, bclk_d;
    logic                 tc;

    assign tc = (cnt_q == DIV_CNT_W'(BCLK_DIV - 1));

    always_comb begin
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (clear_i) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d = cnt_q + DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    // Strobes announce the toggle one cycle early so the frame logic can
    // update sdata/lrck on the same edge that drops bclk.
    assign fall_stb_o = !clear_i && tc && bclk_q;
    assign rise_stb_o = !clear_i && tc && !bclk_q;
    assign bclk_o     = bclk_q;

endmodule

// File: rtl/dac_tx.sv
// dac_tx: left-justified mono serial audio transmitter.
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   enable_i       stream while high; low stops at the next frame boundary
//   sample_in_i    16-bit offset-binary sample (0x8000 = zero level)
//   sample_req_o   one-clk pulse: sample_in_i was latched on the previous edge
//   bclk_o         serial bit clock
//   lrck_o         word select, low = left slot, high = right slot
//   sdata_o        serial data, MSB first, two's complement
module dac_tx
    import dac_pkg::*;
#(
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [WORD_BITS-1:0] sample_in_i,
    output logic                 sample_req_o,
    output logic                 bclk_o,
    output logic                 lrck_o,
    output logic                 sdata_o
);

    localparam int unsigned PosW = $clog2(FRAME_BITS);

    dac_state_e           state_q, state_d;
    logic [PosW-1:0]      pos_q, pos_d, pos_next;
    logic [WORD_BITS-1:0] word_q, word_d, new_word;
    logic                 lrck_q, lrck_d;
    logic                 sdata_q, sdata_d;
    logic                 req_q, req_d;
    logic                 gen_clear, bclk_fall, bclk_rise;

    assign gen_clear = (state_q == StIdle);

    bclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_bclk_gen (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (gen_clear),
        .bclk_o    (bclk_o),
        .fall_stb_o(bclk_fall),
        .rise_stb_o(bclk_rise)
    );

    // Offset-binary to two's complement is just an MSB flip.
    assign new_word = {~sample_in_i[WORD_BITS-1], sample_in_i[WORD_BITS-2:0]};
    assign pos_next = pos_q + PosW'(1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        word_d  = word_q;
        lrck_d  = lrck_q;
        sdata_d = sdata_q;
        req_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable_i) begin
                    // Bit clock is still low here, so presenting word[15] now
                    // lines it up for the first rising edge.
                    state_d = StRun;
                    pos_d   = '0;
                    word_d  = new_word;
                    req_d   = 1'b1;
                    lrck_d  = 1'b0;
                    sdata_d = new_word[WORD_BITS-1];
                end
            end
            StRun, StDrain: begin
                if (state_q == StRun && !enable_i) begin
                    state_d = StDrain;
                end else if (state_q == StDrain && enable_i) begin
                    state_d = StRun;
                end

                if (bclk_fall) begin
                    if (pos_q == PosW'(FRAME_BITS - 1)) begin
                        if (state_q == StRun || enable_i) begin
                            pos_d   = '0;
                            word_d  = new_word;
                            req_d   = 1'b1;
                            lrck_d  = 1'b0;
                            sdata_d = new_word[WORD_BITS-1];
                        end else begin
                            state_d = StIdle;
                            pos_d   = '0;
                            lrck_d  = 1'b0;
                            sdata_d = 1'b0;
                        end
                    end else begin
                        pos_d   = pos_next;
                        lrck_d  = pos_next[PosW-1];
                        // 15 - (p mod 16) is the bitwise inverse of p[3:0].
                        sdata_d = word_q[~pos_next[PosW-2:0]];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            pos_q   <= '0;
            word_q  <= '0;
            lrck_q  <= 1'b0;
            sdata_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            word_q  <= word_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            req_q   <= req_d;
        end
    end

    assign sample_req_o = req_q;
    assign lrck_o       = lrck_q;
    assign sdata_o      = sdata_q;

    // Divider can only announce one direction of toggle per cycle.
    assert property (@(posedge clk_i) disable iff (reset_i) !(bclk_rise && bclk_fall));

endmodule

// File: tb/tb_dac_tx.sv
module tb_dac_tx;

    localparam int unsigned DIV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_req;
    logic        bclk;
    logic        lrck;
    logic        sdata;

    dac_tx #(
        .BCLK_DIV(DIV)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .enable_i    (enable),
        .sample_in_i (sample_in),
        .sample_req_o(sample_req),
        .bclk_o      (bclk),
        .lrck_o      (lrck),
        .sdata_o     (sdata)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp     = 0;
    int unsigned n_bad     = 0;
    int unsigned cyc       = 0;
    int unsigned req_count = 0;
    int unsigned frames    = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, bclk, lrck, sdata, sample_req};
    endfunction

    // Monitor: reassemble each frame from bclk rising edges and score it.
    logic        bclk_prev = 1'b0;
    logic        req_prev  = 1'b0;
    logic        aligned   = 1'b0;
    int          bit_cnt   = 0;
    logic [31:0] sh_d      = '0;
    logic [31:0] sh_l      = '0;

    always @(negedge clk) begin
        if (reset) begin
            aligned   = 1'b0;
            bit_cnt   = 0;
            bclk_prev = 1'b0;
            req_prev  = 1'b0;
        end else begin
            if (sample_req) begin
                req_count++;
                chk("req_width", {31'd0, req_prev}, 32'd0);
                aligned = 1'b1;
                bit_cnt = 0;
            end
            if (bclk && !bclk_prev && aligned) begin
                sh_d = {sh_d[30:0], sdata};
                sh_l = {sh_l[30:0], lrck};
                bit_cnt++;
                if (bit_cnt == 32) begin
                    bit_cnt = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        chk("frame_data", sh_d, exp_q.pop_front());
                        chk("frame_lrck", sh_l, 32'h0000FFFF);
                        frames++;
                    end
                end
            end
            bclk_prev = bclk;
            req_prev  = sample_req;
        end
    end

    task automatic wait_req(input string name, output int unsigned at);
        at = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sample_req === 1'b1) begin
                at = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got no sample_req, expected one within 300 clk", name);
    endtask

    initial begin
        int unsigned t0, t1, t2, t3, rc, c;
        logic [31:0] acc;

        reset     = 1'b1;
        enable    = 1'b0;
        sample_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        reset = 1'b0;

        // Idle with enable low.
        acc = '0;
        repeat (50) begin
            @(negedge clk);
            acc |= outs();
        end
        chk("idle_outputs", acc, 32'd0);
        chk("idle_req_count", req_count, 32'd0);

        // Full-scale positive, then zero level, then full-scale negative.
        sample_in = 16'hFFFF;
        exp_q.push_back(32'h7FFF7FFF);
        enable = 1'b1;
        wait_req("f1", t0);
        exp_q.push_back(32'h7FFF7FFF);
        wait_req("f2", t1);
        chk("period_f2", t1 - t0, 32'd128);
        sample_in = 16'h8000;
        exp_q.push_back(32'h00000000);
        wait_req("f3", t2);
        chk("period_f3", t2 - t1, 32'd128);
        sample_in = 16'h0000;
        exp_q.push_back(32'h80008000);
        wait_req("f4", t3);
        chk("period_f4", t3 - t2, 32'd128);
        enable = 1'b0;
        @(negedge clk);
        rc = req_count;
        repeat (200) @(negedge clk);
        chk("drain_no_req", req_count - rc, 32'd0);
        chk("drain_outputs", outs(), 32'd0);
        chk("frames_basic", frames, 32'd4);

        // Enable dropped at p=5; mid-frame input change must be ignored.
        rc        = req_count;
        sample_in = 16'h1234;
        exp_q.push_back(32'h92349234);
        enable = 1'b1;
        wait_req("f5", t0);
        sample_in = 16'hABCD;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (200) @(negedge clk);
        chk("stop_req_total", req_count - rc, 32'd1);
        chk("stop_outputs", outs(), 32'd0);
        chk("frames_stop", frames, 32'd5);

        // Enable dropped at p=10, re-raised at p=20: no gap.
        sample_in = 16'h0001;
        exp_q.push_back(32'h80018001);
        exp_q.push_back(32'h80018001);
        enable = 1'b1;
        wait_req("f6", t0);
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        enable = 1'b1;
        wait_req("f7", t1);
        chk("period_rearm", t1 - t0, 32'd128);
        enable = 1'b0;
        @(negedge clk);
        repeat (200) @(negedge clk);
        chk("frames_rearm", frames, 32'd7);

        // Reset at p=20, then a fresh frame straight after release.
        sample_in = 16'h5555;
        exp_q.push_back(32'hD555D555);
        enable = 1'b1;
        wait_req("f8", t0);
        repeat (82) @(negedge clk);
        chk("lrck_before_reset", {31'd0, lrck}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", outs(), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c     = cyc;
        wait_req("f9", t1);
        chk("restart_latency", t1 - c, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        repeat (200) @(negedge clk);
        chk("frames_total", frames, 32'd8);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_outputs", outs(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
